keypad_front_end: RTL

Input conditioning stage that sits directly upstream of the combination lock controller. It synchronizes the raw, asynchronous, bouncing button contacts (ten digit keys plus ENTER, CLR and RST) into the system clock domain and debounces them. It presents the lock with a clean one-hot `keypad` level per accepted digit press, and with single-cycle `enter`/`clr`/`rst` pulses. Multi-key digit presses are rejected at this stage, so the downstream BCD encoder only ever sees zero or one active key.

---
 rtl/keypad_front_end.sv | 134 +++++++++++++
 1 files changed

// File: rtl/keypad_front_end.sv
// Keypad input conditioning: 2-FF synchronizers, shared vector debouncer,
// single-digit press FSM and prioritised control pulse generation.
module keypad_front_end #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       hard_rst_n,
  input  logic [9:0] raw_keys,
  input  logic       raw_enter,
  input  logic       raw_clr,
  input  logic       raw_rst,
  output logic [9:0] keypad,
  output logic       enter,
  output logic       clr,
  output logic       rst,
  output logic       multi_err
);

  typedef enum logic [1:0] {StIdle, StPressed, StBlocked} state_e;

  logic [12:0]      r_sync1;
  logic [12:0]      r_sync2;
  logic [12:0]      r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [12:0]      r_stable;
  logic [2:0]       r_ctl_prev;
  state_e           r_state;
  logic [9:0]       r_keypad;
  logic             r_multi_err;
  logic             r_enter;
  logic             r_clr;
  logic             r_rst;

  state_e     w_state_nxt;
  logic [9:0] w_keypad_nxt;
  logic       w_multi_err_nxt;
  logic [9:0] w_d;
  logic       w_d_onehot;
  logic [2:0] w_ctl_rise;

  always_ff @(posedge clk or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= {raw_rst, raw_clr, raw_enter, raw_keys};
      r_sync2 <= r_sync1;
      // One counter for all 13 bits: any change restarts acceptance for every key.
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_stable <= r_cand;
      end
    end
  end

  assign w_d        = r_stable[9:0];
  assign w_d_onehot = (w_d != '0) && ((w_d & (w_d - 10'd1)) == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_keypad_nxt    = r_keypad;
    w_multi_err_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_d_onehot) begin
          w_state_nxt  = StPressed;
          w_keypad_nxt = w_d;
        end else if (w_d != '0) begin
          w_state_nxt     = StBlocked;
          w_multi_err_nxt = 1'b1;
        end
      end
      StPressed: begin
        if (w_d == '0) begin
          w_state_nxt  = StIdle;
          w_keypad_nxt = '0;
        end else if (w_d != r_keypad) begin
          w_state_nxt     = StBlocked;
          w_keypad_nxt    = '0;
          w_multi_err_nxt = 1'b1;
        end
      end
      StBlocked: begin
        // Only a full release re-arms digit acceptance.
        w_keypad_nxt = '0;
        if (w_d == '0) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt  = StIdle;
        w_keypad_nxt = '0;
      end
    endcase
  end

  // Bit order {rst, clr, enter}; same-cycle losers are dropped.
  assign w_ctl_rise = r_stable[12:10] & ~r_ctl_prev;

  always_ff @(posedge clk or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      r_state     <= StIdle;
      r_keypad    <= '0;
      r_multi_err <= 1'b0;
      r_ctl_prev  <= '0;
      r_enter     <= 1'b0;
      r_clr       <= 1'b0;
      r_rst       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_keypad    <= w_keypad_nxt;
      r_multi_err <= w_multi_err_nxt;
      r_ctl_prev  <= r_stable[12:10];
      r_clr       <= w_ctl_rise[1];
      r_enter     <= w_ctl_rise[0] & ~w_ctl_rise[1];
      r_rst       <= w_ctl_rise[2] & ~w_ctl_rise[1] & ~w_ctl_rise[0];
    end
  end

  assign keypad    = r_keypad;
  assign multi_err = r_multi_err;
  assign enter     = r_enter;
  assign clr       = r_clr;
  assign rst       = r_rst;

endmodule
